// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants for the BCD-to-binary converter.
// Holds the FSM state encoding and the BCD digit constants.
// No logic; imported by bcd2bin_seq and bcd_mac_step.
package bcd2bin_seq_pkg;

    // FSM state encoding (2 bits)
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // BCD digit properties
    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Decimal radix applied per digit step: acc*10 = (acc<<3) + (acc<<1)
    localparam int         MULT    = 10;

endpackage

// File: rtl/bcd_mac_step.sv
// One decimal multiply-accumulate step: acc_next = sat(acc*10 + digit).
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   acc       current accumulator (WIDTH bits)
//   digit     BCD digit to append (may be an invalid code > 9)
//   acc_next  saturated result, clamped to 2^WIDTH-1
//   sat       result exceeded 2^WIDTH-1
//   bad_digit digit code is above 9
module bcd_mac_step
    import bcd2bin_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [WIDTH-1:0]   acc_next,
    output logic               sat,
    output logic               bad_digit
);

    // Four guard bits hold the worst case (2^WIDTH-1)*10 + 15 without wrap.
    localparam int              EXT_W = WIDTH + 4;
    localparam logic [EXT_W-1:0] LIMIT = {4'b0000, {WIDTH{1'b1}}};

    logic [EXT_W-1:0] acc_ext;
    logic [EXT_W-1:0] prod;
    logic [EXT_W-1:0] sum;

    assign acc_ext   = {4'b0000, acc};
    // x10 as shift-and-add: 8*acc + 2*acc
    assign prod      = (acc_ext << 3) + (acc_ext << 1);
    assign sum       = prod + {{WIDTH{1'b0}}, digit};

    assign sat       = (sum > LIMIT);
    assign acc_next  = sat ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    assign bad_digit = (digit > BCD_MAX);

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Latency: NDIGITS+1 cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; no queueing of requests.
//
// Ports:
//   sysclk   system clock, rising edge
//   sreset   synchronous reset, active-high; aborts a conversion silently
//   start    conversion request, sampled only while idle
//   bcd_in   packed BCD, [3:0] = units, top nibble = MSD; captured on start
//   bin_out  converted value, held until the next done
//   done     one-cycle pulse, bin_out/ovf/err valid
//   busy     high from the cycle after start through the done cycle
//   ovf      value exceeded 2^WIDTH-1, bin_out saturated
//   err      at least one digit > 9, bin_out forced to 0
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int NDIGITS = 5,
    parameter int WIDTH   = 16
) (
    input  logic                   sysclk,
    input  logic                   sreset,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   bcd_in,
    output logic [WIDTH-1:0]       bin_out,
    output logic                   done,
    output logic                   busy,
    output logic                   ovf,
    output logic                   err
);

    localparam int BCD_W = DIGIT_W * NDIGITS;
    localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIGITS - 1);

    logic [ST_W-1:0]  state;
    logic [BCD_W-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic             ovf_sticky;
    logic             err_sticky;

    logic [WIDTH-1:0] mac_acc;
    logic             mac_sat;
    logic             mac_bad;

    // Flags including the step being taken this cycle; used on the last
    // digit so the output registers see the final sticky state directly.
    logic             ovf_final;
    logic             err_final;

    bcd_mac_step #(
        .WIDTH (WIDTH)
    ) u_mac (
        .acc       (acc),
        .digit     (shreg[BCD_W-1 -: DIGIT_W]),
        .acc_next  (mac_acc),
        .sat       (mac_sat),
        .bad_digit (mac_bad)
    );

    assign ovf_final = ovf_sticky | mac_sat;
    assign err_final = err_sticky | mac_bad;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge sysclk) begin
        if (sreset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            err_sticky <= 1'b0;
            bin_out    <= '0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg      <= bcd_in;
                        acc        <= '0;
                        ovf_sticky <= 1'b0;
                        err_sticky <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_CONV;
                    end
                end

                ST_CONV: begin
                    // Once saturated, acc*10+d stays above the limit, so the
                    // clamp holds for the remaining digits without extra state.
                    acc        <= mac_acc;
                    ovf_sticky <= ovf_final;
                    err_sticky <= err_final;
                    shreg      <= {shreg[BCD_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
                    cnt        <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        // Results land on entry to DONE so they are valid
                        // during the done pulse. An invalid digit wins over
                        // overflow and zeroes the value.
                        cnt     <= '0;
                        state   <= ST_DONE;
                        bin_out <= err_final ? '0 : mac_acc;
                        err     <= err_final;
                        ovf     <= ovf_final & ~err_final;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;
    import bcd2bin_seq_pkg::*;

    localparam int NDIGITS = 5;
    localparam int WIDTH   = 16;

    logic                 sysclk = 1'b0;
    logic                 sreset;
    logic                 start;
    logic [4*NDIGITS-1:0] bcd_in;
    logic [WIDTH-1:0]     bin_out;
    logic                 done;
    logic                 busy;
    logic                 ovf;
    logic                 err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    int          m_left = 0;        // remaining busy cycles, 0 = idle
    logic [17:0] m_pend = '0;       // {err, ovf, bin} of the accepted request
    logic [15:0] m_bin  = '0;
    logic        m_ovf  = 1'b0;
    logic        m_err  = 1'b0;

    bcd2bin_seq #(
        .NDIGITS (NDIGITS),
        .WIDTH   (WIDTH)
    ) dut (
        .sysclk  (sysclk),
        .sreset  (sreset),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .done    (done),
        .busy    (busy),
        .ovf     (ovf),
        .err     (err)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%h required=0x%h", nm, act, exp);
        end
    endtask

    // Decimal value of the BCD word, returned as {err, ovf, bin}.
    function automatic logic [17:0] ref_conv(input logic [4*NDIGITS-1:0] bcd);
        int val;
        bit bad;
        val = 0;
        bad = 1'b0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            int d;
            d = int'(bcd[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            val = val * MULT + d;
        end
        if (bad)
            return {1'b1, 1'b0, 16'h0000};
        else if (val > 65535)
            return {1'b0, 1'b1, 16'hFFFF};
        else
            return {1'b0, 1'b0, val[15:0]};
    endfunction

    function automatic logic [4*NDIGITS-1:0] rand_bcd();
        logic [4*NDIGITS-1:0] v;
        bit wild;
        v = '0;
        wild = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < NDIGITS; i++) begin
            if (wild)
                v[4*i +: 4] = 4'($urandom_range(0, 15));
            else if (i == NDIGITS - 1)
                v[4*i +: 4] = 4'($urandom_range(4, 9));
            else
                v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Model: an accepted start produces NDIGITS+1 busy cycles, the last of
    // which is the done cycle where the results appear.
    always @(posedge sysclk) begin
        if (sreset) begin
            m_left = 0;
            m_bin  = '0;
            m_ovf  = 1'b0;
            m_err  = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_pend = ref_conv(bcd_in);
                m_left = NDIGITS + 1;
            end
        end else begin
            m_left--;
            if (m_left == 1) {m_err, m_ovf, m_bin} = m_pend;
        end
    end

    always @(negedge sysclk) begin
        if (chk_en)
            chk("cycle", {12'h0, busy, done, ovf, err, bin_out},
                {12'h0, m_left != 0, m_left == 1, m_ovf, m_err, m_bin});
    end

    task automatic run_conv(input logic [19:0] bcd, input logic [15:0] eb,
                            input logic eo, input logic ee, input string nm);
        int lat;
        lat = 0;
        @(posedge sysclk); #1;
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge sysclk); #1;
        start  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge sysclk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_latency"}, lat, 6);
        chk(nm, {14'h0, ovf, err, bin_out}, {14'h0, eo, ee, eb});
    endtask

    initial begin
        int nd;
        int first_i;
        int second_i;
        logic [15:0] got;

        sreset = 1'b1;
        start  = 1'b0;
        bcd_in = '0;

        // Pin the reference model with hand-computed values
        chk("ref_12345", {14'h0, ref_conv(20'h12345)}, {14'h0, 18'h03039});
        chk("ref_65536", {14'h0, ref_conv(20'h65536)}, {14'h0, 18'h1FFFF});
        chk("ref_1A345", {14'h0, ref_conv(20'h1A345)}, {14'h0, 18'h20000});
        chk("ref_11111", {14'h0, ref_conv(20'h11111)}, {14'h0, 18'h02B67});

        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("reset_state", {12'h0, busy, done, ovf, err, bin_out}, 32'h0);
        chk_en = 1'b1;
        @(posedge sysclk); #1;
        sreset = 1'b0;

        run_conv(20'h12345, 16'h3039, 1'b0, 1'b0, "conv_12345");
        run_conv(20'h65535, 16'hFFFF, 1'b0, 1'b0, "conv_65535");
        run_conv(20'h65536, 16'hFFFF, 1'b1, 1'b0, "conv_65536");
        run_conv(20'h99999, 16'hFFFF, 1'b1, 1'b0, "conv_99999");
        run_conv(20'h1A345, 16'h0000, 1'b0, 1'b1, "conv_1A345");
        run_conv(20'h00042, 16'h002A, 1'b0, 1'b0, "conv_00042");
        run_conv(20'h00000, 16'h0000, 1'b0, 1'b0, "conv_00000");

        // Second start while busy must be ignored
        @(posedge sysclk); #1;
        start  = 1'b1;
        bcd_in = 20'h00100;
        @(posedge sysclk); #1;
        start  = 1'b0;
        bcd_in = 20'h00999;
        @(posedge sysclk); #1;
        start  = 1'b1;
        @(posedge sysclk); #1;
        start  = 1'b0;
        nd  = 0;
        got = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge sysclk);
            if (done === 1'b1) begin
                nd++;
                got = bin_out;
            end
        end
        chk("ignored_start_dones", nd, 1);
        chk("ignored_start_bin", {16'h0, got}, 32'h0064);

        // Start held high for 14 sampling edges
        @(posedge sysclk); #1;
        start  = 1'b1;
        bcd_in = 20'h00042;
        nd = 0;
        first_i = -1;
        second_i = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge sysclk); #1;
            if (i == 13) start = 1'b0;
            @(negedge sysclk);
            if (done === 1'b1) begin
                if (nd == 0) first_i = i;
                else if (nd == 1) second_i = i;
                nd++;
            end
        end
        chk("held_start_dones", nd, 2);
        chk("held_start_spacing", second_i - first_i, 7);

        // Reset during conversion aborts without a done
        @(posedge sysclk); #1;
        start  = 1'b1;
        bcd_in = 20'h54321;
        @(posedge sysclk); #1;
        start  = 1'b0;
        @(posedge sysclk);
        @(posedge sysclk); #1;
        sreset = 1'b1;
        @(posedge sysclk); #1;
        sreset = 1'b0;
        @(negedge sysclk);
        chk("abort_outputs", {12'h0, busy, done, ovf, err, bin_out}, 32'h0);
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sysclk);
            if (done === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);
        run_conv(20'h00007, 16'h0007, 1'b0, 1'b0, "conv_after_abort");

        // bcd_in changes after capture must not matter
        @(posedge sysclk); #1;
        start  = 1'b1;
        bcd_in = 20'h11111;
        @(posedge sysclk); #1;
        start  = 1'b0;
        @(posedge sysclk); #1;
        bcd_in = 20'h99999;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sysclk);
            if (done === 1'b1) begin
                nd = 1;
                break;
            end
        end
        chk("midchange_done_seen", nd, 1);
        chk("midchange_result", {14'h0, ovf, err, bin_out}, 32'h2B67);

        // Randomized traffic checked cycle-by-cycle against the model
        for (int c = 0; c < 600; c++) begin
            @(posedge sysclk); #1;
            start  = ($urandom_range(0, 2) == 0);
            bcd_in = rand_bcd();
            sreset = ($urandom_range(0, 149) == 0);
        end
        @(posedge sysclk); #1;
        start  = 1'b0;
        sreset = 1'b0;
        repeat (12) @(posedge sysclk);
        @(negedge sysclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter, the inverse of the display path's binary-to-BCD decode.
- Accepts NDIGITS packed BCD digits, for example a target or threshold time entered on switches or keys, and produces an unsigned WIDTH-bit binary value usable by the timer/delay counters.
- Processes one digit per clock, most significant digit (MSD) first.
- Uses a start/busy/done handshake and flags invalid digits and overflow.

Parameters:
- NDIGITS, 5, number of BCD digits on bcd_in
- WIDTH, 16, width of binary result

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- sreset  in  1  synchronous reset, active-high
- start  in  1  request conversion; sampled only when busy=0
- bcd_in  in  4*NDIGITS  packed BCD; [3:0]=units, [4*NDIGITS-1:4*NDIGITS-4]=MSD; captured on accepted start
- bin_out  out  WIDTH  converted value; held until next done
- done  out  1  one-cycle pulse; bin_out/ovf/err valid
- busy  out  1  high from the cycle after accepted start through the done cycle
- ovf  out  1  value exceeded 2^WIDTH-1; bin_out saturated
- err  out  1  at least one digit >9; bin_out=0

Behaviour:
- Reset: on sreset=1 at a clock edge:
  - bin_out=0, done=0, busy=0, ovf=0, err=0, state=IDLE, digit counter=0, accumulator=0.
  - Reset has priority over start and aborts any conversion in progress; no done is produced for the aborted request.
- FSM:
  - IDLE: start=1 -> latch bcd_in into a shift register, clear acc, clear sticky ovf/err, set cnt=0, go to CONV.
  - CONV: each cycle take the MSD from the shift register.
    - acc_next = acc*10 + digit, where acc*10 = (acc<<3)+(acc<<1); compute in WIDTH+4 bits.
    - If acc_next > 2^WIDTH-1: set sticky ovf and clamp acc to 2^WIDTH-1. Later steps keep it clamped.
    - If digit > 9: set sticky err; digit value still applied (result discarded).
    - Shift register left 4; cnt++. When cnt=NDIGITS-1, go to DONE.
  - DONE: done=1 for this cycle.
    - bin_out = err ? 0 : acc(WIDTH bits); ovf/err outputs loaded from the sticky flags. err takes precedence: if err=1, ovf output=0.
    - Next state IDLE.
- Timing:
  - start sampled at edge T -> busy=1 during T+1..T+NDIGITS+1.
  - done=1 and bin_out/ovf/err updated in cycle T+NDIGITS+1.
  - Latency = NDIGITS+1 cycles.
  - Next start may be accepted at the first edge after done, back-to-back (IDLE for one cycle).
- start while busy=1 is ignored (no queueing); bcd_in changes during conversion have no effect.
- start held high continuously -> a new conversion every NDIGITS+2 cycles.
- bin_out, ovf and err hold their values between done pulses; they change only in the DONE state or on reset.
- Leading zeros are legal. All-zero input -> bin_out=0, flags 0.

Decomposition:
- Shared package:
  - state encoding IDLE/CONV/DONE (2 bits)
  - BCD_MAX=9
  - digit width constant 4
  - multiplier constant 10
- Sub-module bcd_mac_step (combinational):
  - inputs: acc[WIDTH-1:0], digit[3:0]
  - outputs: acc_next[WIDTH-1:0] (saturated), sat, bad_digit
  - Instantiated once; top holds FSM, counter, shift register, output registers.

Test Plan:
- Reset, then start with bcd_in=0x12345 (T) -> busy=1 for T+1..T+6; done pulse at T+6 only; bin_out=0x3039; ovf=0; err=0.
- bcd_in=0x65535 -> bin_out=0xFFFF, ovf=0. Then bcd_in=0x65536 -> bin_out=0xFFFF, ovf=1. Then bcd_in=0x99999 -> bin_out=0xFFFF, ovf=1, err=0.
- bcd_in=0x1A345 (digit 0xA) -> done at T+6, err=1, bin_out=0, ovf=0. Following conversion of 0x00042 -> err=0, bin_out=0x002A.
- Start accepted with 0x00100; pulse start again at T+2 with 0x00999 -> single done, bin_out=0x0064. Then start held high for 14 cycles -> exactly 2 done pulses, 7 cycles apart.
- Start with 0x54321, sreset at T+3 -> all outputs 0 the next cycle, no done pulse. Start after reset with 0x00007 -> bin_out=0x0007 at latency 6.
- bcd_in=0x00000 -> bin_out=0, ovf=0, err=0. bcd_in changed mid-conversion (0x11111 -> 0x99999 at T+2) -> bin_out=0x2B67 (11111).
